// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encodings
// and the default counter width.
package timer_pkg;

    localparam int DEF_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t RUN     = 2'd1;
    localparam state_t EXPIRED = 2'd2;

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle of the countdown timer.
// master: load, load_value, en, auto_reload out; count, tc, busy, done in.
// slave : the timer side of the same signals.
interface countdown_timer_if
    import timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output load, load_value, en, auto_reload,
        input  count, tc, busy, done
    );

    modport slave (
        input  load, load_value, en, auto_reload,
        output count, tc, busy, done
    );
endinterface

// File: rtl/countdown_timer_prescaler.sv
// Prescaler: raises tick on every PRESCALE-th enabled cycle.
// Ports: clk, rst (sync, active high), clr (sync clear), en, tick.
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = $clog2(PRESCALE) + 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_cnt;

    // With PRESCALE=1 the counter never leaves 0, so tick == en.
    assign tick = en && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (r_cnt == LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counting timer with prescaler, one-shot/auto-reload
// and a registered one-cycle terminal-count pulse.
// Ports: clk, rst (sync, active high), bus (countdown_timer_if.slave).
module countdown_timer
    import timer_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PRESCALE = 1
) (
    input  logic               clk,
    input  logic               rst,
    countdown_timer_if.slave   bus
);
    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_tc;

    logic w_run;
    logic w_tick;

    assign w_run = (r_state == RUN);

    // A load restarts the prescaler phase; leaving RUN also clears it.
    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_pre (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.load || !w_run),
        .en   (bus.en && w_run),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
        end else if (bus.load) begin
            r_count  <= bus.load_value;
            r_reload <= bus.load_value;
            r_tc     <= 1'b0;
            r_state  <= (bus.load_value != '0) ? RUN : IDLE;
        end else begin
            r_tc <= 1'b0;
            case (r_state)
                RUN: begin
                    if (w_tick) begin
                        // count is >=1 in RUN; 1 is the terminal value
                        if (r_count > WIDTH'(1)) begin
                            r_count <= r_count - WIDTH'(1);
                        end else if (bus.auto_reload) begin
                            r_count <= r_reload;
                            r_tc    <= 1'b1;
                        end else begin
                            r_count <= '0;
                            r_tc    <= 1'b1;
                            r_state <= EXPIRED;
                        end
                    end
                end
                EXPIRED: r_count <= '0;
                IDLE:    r_count <= r_count;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.count = r_count;
    assign bus.tc    = r_tc;
    assign bus.busy  = w_run;
    assign bus.done  = (r_state == EXPIRED);
endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer (PRESCALE=1 and PRESCALE=4).
// Expected observations are queued per cycle and popped after each edge.
module tb_countdown_timer;
    import timer_pkg::*;

    typedef struct packed {
        logic [7:0] c;
        logic       tc;
        logic       busy;
        logic       done;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    obs_t sb[$];

    always #5 clk = ~clk;

    countdown_timer_if #(.WIDTH(8)) a1 ();
    countdown_timer_if #(.WIDTH(8)) a4 ();

    countdown_timer #(.WIDTH(8), .PRESCALE(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (a1.slave)
    );

    countdown_timer #(.WIDTH(8), .PRESCALE(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (a4.slave)
    );

    function automatic obs_t mk(int c, bit tc, bit b, bit d);
        obs_t o;
        o.c    = 8'(c);
        o.tc   = tc;
        o.busy = b;
        o.done = d;
        return o;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        obs_t e, g;
        rst = 1'b1;
        a1.load = 1'b1; a1.load_value = 8'd42;
        a1.en = 1'b1; a1.auto_reload = 1'b0;
        a4.load = 1'b1; a4.load_value = 8'd42;
        a4.en = 1'b1; a4.auto_reload = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sb.push_back(mk(0, 0, 0, 0));
            step;
            e = sb.pop_front();
            g = {a1.count, a1.tc, a1.busy, a1.done};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL reset k=%0d got c=%0d tc=%b busy=%b done=%b exp c=%0d tc=%b busy=%b done=%b",
                         k, g.c, g.tc, g.busy, g.done, e.c, e.tc, e.busy, e.done);
            end
            e = sb.pop_front();
        end
        rst = 1'b0;
        a1.load = 1'b0;
        a4.load = 1'b0;
        a4.en = 1'b0;
    endtask

    task automatic test_oneshot;
        obs_t e, g;
        a1.en = 1'b1; a1.auto_reload = 1'b0; a1.load_value = 8'd42;
        for (int k = 0; k <= 52; k++) begin
            a1.load = (k == 0);
            if (k == 0)       sb.push_back(mk(42, 0, 1, 0));
            else if (k < 42)  sb.push_back(mk(42 - k, 0, 1, 0));
            else if (k == 42) sb.push_back(mk(0, 1, 0, 1));
            else              sb.push_back(mk(0, 0, 0, 1));
            step;
            e = sb.pop_front();
            g = {a1.count, a1.tc, a1.busy, a1.done};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL oneshot k=%0d got c=%0d tc=%b busy=%b done=%b exp c=%0d tc=%b busy=%b done=%b",
                         k, g.c, g.tc, g.busy, g.done, e.c, e.tc, e.busy, e.done);
            end
        end
        a1.load = 1'b0;
    endtask

    task automatic test_auto_reload;
        obs_t e, g;
        a1.en = 1'b1; a1.auto_reload = 1'b1; a1.load_value = 8'd3;
        for (int k = 0; k <= 12; k++) begin
            a1.load = (k == 0);
            sb.push_back(mk(3 - (k % 3), (k > 0) && (k % 3 == 0), 1, 0));
            step;
            e = sb.pop_front();
            g = {a1.count, a1.tc, a1.busy, a1.done};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL autoreload k=%0d got c=%0d tc=%b busy=%b done=%b exp c=%0d tc=%b busy=%b done=%b",
                         k, g.c, g.tc, g.busy, g.done, e.c, e.tc, e.busy, e.done);
            end
        end
        a1.load = 1'b0;
    endtask

    task automatic test_reload_one;
        obs_t e, g;
        a1.en = 1'b1; a1.auto_reload = 1'b1; a1.load_value = 8'd1;
        for (int k = 0; k <= 4; k++) begin
            a1.load = (k == 0);
            sb.push_back(mk(1, k > 0, 1, 0));
            step;
            e = sb.pop_front();
            g = {a1.count, a1.tc, a1.busy, a1.done};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL reload1 k=%0d got c=%0d tc=%b busy=%b done=%b exp c=%0d tc=%b busy=%b done=%b",
                         k, g.c, g.tc, g.busy, g.done, e.c, e.tc, e.busy, e.done);
            end
        end
        a1.load = 1'b0;
    endtask

    task automatic test_enable_gating;
        obs_t e, g;
        a1.auto_reload = 1'b0; a1.load_value = 8'd42;
        for (int k = 0; k <= 29; k++) begin
            a1.load = (k == 0);
            a1.en   = !(k >= 23 && k <= 27);
            if (k <= 22)      sb.push_back(mk(42 - k, 0, 1, 0));
            else if (k <= 27) sb.push_back(mk(20, 0, 1, 0));
            else              sb.push_back(mk(19 - (k - 28), 0, 1, 0));
            step;
            e = sb.pop_front();
            g = {a1.count, a1.tc, a1.busy, a1.done};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL engate k=%0d got c=%0d tc=%b busy=%b done=%b exp c=%0d tc=%b busy=%b done=%b",
                         k, g.c, g.tc, g.busy, g.done, e.c, e.tc, e.busy, e.done);
            end
        end
        a1.load = 1'b0;
        a1.en = 1'b1;
    endtask

    task automatic test_collision;
        obs_t e, g;
        a1.en = 1'b1; a1.auto_reload = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            a1.load = (k == 0) || (k == 2) || (k == 3);
            case (k)
                0: a1.load_value = 8'd2;
                2: a1.load_value = 8'd42;
                3: a1.load_value = 8'd0;
                default: a1.load_value = 8'd7;
            endcase
            case (k)
                0: sb.push_back(mk(2, 0, 1, 0));
                1: sb.push_back(mk(1, 0, 1, 0));
                2: sb.push_back(mk(42, 0, 1, 0));
                default: sb.push_back(mk(0, 0, 0, 0));
            endcase
            step;
            e = sb.pop_front();
            g = {a1.count, a1.tc, a1.busy, a1.done};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL collision k=%0d got c=%0d tc=%b busy=%b done=%b exp c=%0d tc=%b busy=%b done=%b",
                         k, g.c, g.tc, g.busy, g.done, e.c, e.tc, e.busy, e.done);
            end
        end
        a1.load = 1'b0;
    endtask

    task automatic test_prescale;
        obs_t e, g;
        a4.en = 1'b1; a4.auto_reload = 1'b0; a4.load_value = 8'd2;
        for (int k = 0; k <= 10; k++) begin
            a4.load = (k == 0);
            if (k < 4)        sb.push_back(mk(2, 0, 1, 0));
            else if (k < 8)   sb.push_back(mk(1, 0, 1, 0));
            else if (k == 8)  sb.push_back(mk(0, 1, 0, 1));
            else              sb.push_back(mk(0, 0, 0, 1));
            step;
            e = sb.pop_front();
            g = {a4.count, a4.tc, a4.busy, a4.done};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL prescale k=%0d got c=%0d tc=%b busy=%b done=%b exp c=%0d tc=%b busy=%b done=%b",
                         k, g.c, g.tc, g.busy, g.done, e.c, e.tc, e.busy, e.done);
            end
        end
        a4.load = 1'b0;
    endtask

    task automatic test_reset_midrun;
        obs_t e, g;
        a1.en = 1'b1; a1.auto_reload = 1'b0; a1.load_value = 8'd3;
        for (int k = 0; k <= 5; k++) begin
            a1.load = (k == 0);
            rst     = (k == 3);
            if (k < 3) sb.push_back(mk(3 - k, 0, 1, 0));
            else       sb.push_back(mk(0, 0, 0, 0));
            step;
            e = sb.pop_front();
            g = {a1.count, a1.tc, a1.busy, a1.done};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL rstmid k=%0d got c=%0d tc=%b busy=%b done=%b exp c=%0d tc=%b busy=%b done=%b",
                         k, g.c, g.tc, g.busy, g.done, e.c, e.tc, e.busy, e.done);
            end
        end
        rst = 1'b0;
        a1.load = 1'b0;
    endtask

    initial begin
        test_reset;
        test_oneshot;
        test_auto_reload;
        test_reload_one;
        test_enable_gating;
        test_collision;
        test_prescale;
        test_reset_midrun;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counting timer with enable, prescaler, one-shot and auto-reload modes, and a single-cycle terminal-count pulse. It is the consuming counterpart to the loadable up-counter. Software or control logic loads a period, and the block counts it down to zero and signals expiry. It sits beside the counter in the timing/control path and drives interrupt or handshake logic from `tc`.

## Interface
Parameters:
- `WIDTH`, 8: width of `load_value` and `count`.
- `PRESCALE`, 1: enabled cycles per decrement. Must be ≥1; 1 means decrement on every enabled cycle.

Ports:
- `clk`, input, 1: single clock, all logic on rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `load`, input, 1: load `load_value` into `count` and the reload register.
- `load_value`, input, WIDTH: period to load.
- `en`, input, 1: count enable; gates both the prescaler and the decrement.
- `auto_reload`, input, 1: sampled on the terminal tick. 1 = reload and keep running; 0 = one-shot.
- `count`, output, WIDTH: current remaining count.
- `tc`, output, 1: terminal-count pulse, one cycle, registered.
- `busy`, output, 1: high in RUN.
- `done`, output, 1: high in EXPIRED (one-shot finished).

## Operation
- FSM states: IDLE, RUN, EXPIRED.
- Reset (`rst`=1 at a rising edge):
  - `count`=0, reload register=0, prescaler=0, `tc`=0.
  - State → IDLE, so `busy`=0 and `done`=0.
  - `rst` overrides everything, in any state and mid-count.
- Load (`load`=1, any state):
  - `count` ← `load_value`, reload register ← `load_value`, prescaler ← 0, `tc` ← 0.
  - Next state is RUN if `load_value`≠0, otherwise IDLE.
  - Load has priority over `en` and over a coincident terminal tick; no `tc` is issued in that case.
- Tick:
  - `tick` = `en` && state==RUN && prescaler==PRESCALE-1.
  - The prescaler counts 0..PRESCALE-1 only while `en` && RUN, and wraps to 0 on tick.
  - It holds when `en`=0, and clears outside RUN.
- RUN, on tick:
  - `count`>1: `count` ← `count`-1.
  - `count`==1 and `auto_reload`=1: `count` ← reload register, `tc`=1, stay in RUN.
  - `count`==1 and `auto_reload`=0: `count` ← 0, `tc`=1, go to EXPIRED.
- RUN, no tick: `count` holds; `tc`=0.
- EXPIRED: `count` holds 0 and `done`=1 until the next load or reset.
- IDLE: `count` holds; waits for load.
- Arithmetic: unsigned, WIDTH bits. `count` never decrements below 0 and never wraps.
- Reload value 1 with auto-reload: `tc` on every tick, and `count` stays at 1.

## Timing
- Load latency: `load` sampled at edge N gives `count`=`load_value` after edge N.
- Decrement: visible after the edge on which the tick is true.
- With PRESCALE=1 and `en` held high, a load of L at edge N gives:
  - `count`=0 and `tc`=1 after edge N+L;
  - in one-shot mode, `done`=1 from the same edge.
- `tc` is high for exactly one cycle per expiry or reload event. It is registered and aligned with the `count` update.
- The auto-reload period is L×PRESCALE enabled cycles between `tc` pulses.
- `busy` and `done` are decoded directly from registered state, with no extra latency.

## Structure
- Shared package `timer_pkg`:
  - state encodings as localparams: IDLE=2'd0, RUN=2'd1, EXPIRED=2'd2;
  - a common WIDTH default.
- Sub-module `tick_prescaler`:
  - parameter `PRESCALE`;
  - inputs `clk`, `rst`, `clr`, `en`; output `tick`;
  - counter width $clog2(PRESCALE)+1;
  - PRESCALE=1 degenerates to `tick`=`en`.
- The top level holds the FSM, `count`, the reload register and the `tc` register.

## Test plan
- Reset: hold `rst` 2 cycles with `load`=1 and `load_value`=42 → `count`=0, `tc`=0, `busy`=0, `done`=0.
- One-shot: PRESCALE=1, `en`=1, `auto_reload`=0, load 42 → `count`=41 after 1 edge and 0 after 42 edges; `tc` high exactly 1 cycle; `done`=1 and `count` holds 0 for 10 more cycles.
- Auto-reload: load 3, `auto_reload`=1 → `count` sequence 3,2,1,3,2,1,…; `tc` every 3rd cycle, aligned with each reload to 3; `busy` stays 1.
- Enable gating: load 42, then drop `en` for 5 cycles while `count`=20 → `count` holds 20, and the countdown resumes at 19 when `en` returns.
- Collisions:
  - load 42 on the same edge as the terminal tick (`count`=1) → `count`=42, `tc`=0;
  - load 0 → IDLE, `busy`=0, no `tc`.
- Prescale and reset:
  - PRESCALE=4 instance, load 2 → `tc` after 8 enabled cycles;
  - assert `rst` mid-run at `count`=1 → all outputs zero after that edge.
